// File: rtl/instr_fetch_sequencer_pkg.sv
// ISA constants shared by the fetch path: widths, opcodes, field helpers, fetch state encoding.
package instr_fetch_sequencer_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_ALU   = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LOAD  = 6'b100011;
    localparam logic [5:0] OP_STORE = 6'b101011;
    localparam logic [5:0] OP_JUMP  = 6'b010100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [15:0] imm16_of(input logic [INSTR_W-1:0] instr);
        return instr[15:0];
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer.sv
// Purpose: owns the PC, addresses the combinational imem, buffers one fetched word for decode.
// Latency: 1 cycle pc -> out_instr; one word per cycle while out_ready is held high.
// Backpressure: out_valid && !out_ready freezes buffer, pc and state; redirect flushes the buffer.
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 32,
    parameter logic [15:0]     RESET_PC = 16'h0000,
    parameter logic [5:0]      OP_JUMP  = 6'b010100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              xfer;
    logic              load;
    logic              self_jump;

    assign imem_addr = pc;
    assign xfer      = out_valid && out_ready;
    assign load      = !out_valid || out_ready;
    // A jump whose target is its own address is the software halt idiom.
    assign self_jump = (opcode_of(imem_instr) == OP_JUMP) &&
                       (imm16_of(imem_instr) == 16'(pc));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= ADDR_W'(RESET_PC);
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (xfer && (fetch_count != 32'hFFFF_FFFF)) begin
                fetch_count <= fetch_count + 32'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (start) begin
                        state <= ST_RUN;
                    end
                    if (xfer) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_RUN, ST_HALT: begin
                    if (redirect_valid) begin
                        out_valid <= 1'b0;
                        pc        <= redirect_pc;
                        halted    <= 1'b0;
                        state     <= ST_RUN;
                    end else if ((state == ST_RUN) && load) begin
                        out_instr <= imem_instr;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                        if (self_jump) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end else if (xfer) begin
                        // Halted: let the last word drain without refilling.
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_pc;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [65536];
    logic [15:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    instr_fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted word must match the next expected pc and its memory contents.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_xfer", {16'h0, out_pc}, 32'hDEAD);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("sb_pc", {16'h0, out_pc}, {16'h0, e});
                check("sb_instr", out_instr, mem[e]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'hA500_0000 | i;
        mem[19] = 32'b010100_11111_00000_00000_00000_010011;

        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid",  {31'h0, out_valid}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_count",  fetch_count, 32'h0);
        check("rst_addr",   {16'h0, imem_addr}, 32'h0);
        check("rst_pc",     {16'h0, out_pc}, 32'h0);
        check("rst_instr",  out_instr, 32'h0);
        tick();
        check("idle_no_fetch", {31'h0, out_valid}, 32'h0);

        // Basic streaming plus a 3-cycle stall with buffer holding pc 1.
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("run_first_empty", {31'h0, out_valid}, 32'h0);
        tick();
        check("t1_valid", {31'h0, out_valid}, 32'h1);
        check("t1_pc0", {16'h0, out_pc}, 32'h0);
        tick();
        check("t1_pc1", {16'h0, out_pc}, 32'h1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc",    {16'h0, out_pc}, 32'h1);
            check("stall_instr", out_instr, mem[1]);
            check("stall_addr",  {16'h0, imem_addr}, 32'h2);
            check("stall_count", fetch_count, 32'h1);
        end
        out_ready = 1'b1;
        tick();
        check("resume_pc2", {16'h0, out_pc}, 32'h2);
        tick();
        check("resume_pc3", {16'h0, out_pc}, 32'h3);
        tick();
        check("resume_pc4", {16'h0, out_pc}, 32'h4);
        check("count4", fetch_count, 32'h4);

        // Redirect with a full, stalled buffer: word at pc 4 is flushed, never delivered.
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush", {31'h0, out_valid}, 32'h0);
        check("redir_addr",  {16'h0, imem_addr}, 32'h10);
        for (int i = 16; i < 20; i++) exp_q.push_back(16'(i));
        out_ready = 1'b1;
        tick();
        check("redir_valid", {31'h0, out_valid}, 32'h1);
        check("redir_pc",    {16'h0, out_pc}, 32'h10);
        tick(); tick(); tick();
        check("halt_pc",     {16'h0, out_pc}, 32'h13);
        check("halt_instr",  out_instr, 32'h53E0_0013);
        check("halt_flag",   {31'h0, halted}, 32'h1);
        check("halt_addr",   {16'h0, imem_addr}, 32'h13);
        tick();
        check("halt_drained", {31'h0, out_valid}, 32'h0);
        tick();
        check("halt_no_more", {31'h0, out_valid}, 32'h0);
        check("halt_still",   {31'h0, halted}, 32'h1);
        check("count8",       fetch_count, 32'h8);

        // Leave HALT through a redirect to 0.
        redirect_valid = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect_valid = 1'b0;
        check("unhalt_flag",  {31'h0, halted}, 32'h0);
        check("unhalt_valid", {31'h0, out_valid}, 32'h0);
        exp_q.push_back(16'h0);
        tick();
        check("unhalt_pc0", {16'h0, out_pc}, 32'h0);
        tick();
        check("unhalt_pc1", {16'h0, out_pc}, 32'h1);
        out_ready = 1'b0;

        // Reset mid-run with a full buffer.
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_count", fetch_count, 32'h0);
        check("mid_rst_addr",  {16'h0, imem_addr}, 32'h0);
        tick(); tick();
        check("mid_rst_idle", {31'h0, out_valid}, 32'h0);

        // Wrap: IDLE redirect to FFFF, then start.
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        check("idle_redir_addr",  {16'h0, imem_addr}, 32'hFFFF);
        check("idle_redir_valid", {31'h0, out_valid}, 32'h0);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("wrap_ffff", {16'h0, out_pc}, 32'hFFFF);
        tick();
        check("wrap_0000", {16'h0, out_pc}, 32'h0);
        check("wrap_addr", {16'h0, imem_addr}, 32'h1);
        tick();
        out_ready = 1'b0;
        check("wrap_count", fetch_count, 32'h2);
        tick();
        check("sb_drained", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
